hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Generates the `pause` consumed by the ID/EXE pipeline register, plus the matching PC and IF/ID hold signals.
- Detects load-use hazards between the instruction in ID and a load in EXE; inserts exactly one bubble.
- Runs a counter-driven state machine that holds a multi-cycle multiply/divide instruction in ID for a configurable number of cycles, injecting bubbles until the MDU result is ready.
- Sits beside the ID stage, between the decoder/register file and the ID/EXE register.

## Interface
Parameters:
- `MUL_CYCLES`, default 4, stall cycles for a multiply; legal range 1..63.
- `DIV_CYCLES`, default 32, stall cycles for a divide; legal range 1..63.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rs`  in  1  ID instruction reads rs.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `id_mdu_start`  in  1  ID instruction is a multi-cycle MDU op.
- `id_mdu_div`  in  1  1 = divide, 0 = multiply; valid with `id_mdu_start`.
- `ex_reg_write_addr`  in  5  destination register of the instruction in EXE.
- `ex_RegWE`  in  1  EXE instruction writes the register file.
- `ex_is_load`  in  1  EXE instruction writes back memory data.
- `pc_hold`  out  1  freeze PC.
- `if_id_hold`  out  1  freeze IF/ID register.
- `pause`  out  1  drive the ID/EXE `pause` input; loads a bubble.
- `mdu_busy`  out  1  state is BUSY.
- `mdu_done`  out  1  one-cycle pulse on the release cycle of an MDU stall.
- `stall_cycles`  out  32  stall performance counter (see Configuration).

## Operation
- Load-use hazard: `lu` = `ex_is_load & ex_RegWE & (ex_reg_write_addr != 0) & ((id_uses_rs & id_rs == ex_reg_write_addr) | (id_uses_rt & id_rt == ex_reg_write_addr))`.
- States: IDLE, BUSY. 6-bit down-counter `cnt`.
- IDLE:
  - `lu` = 1: assert `pc_hold`, `if_id_hold` and `pause` combinationally this cycle. State stays IDLE; MDU start is ignored this cycle.
  - `lu` = 0 and `id_mdu_start` = 1: assert all three holds. Load `cnt` = (`id_mdu_div` ? `DIV_CYCLES` : `MUL_CYCLES`) − 1. Go to BUSY.
  - Otherwise: all outputs 0.
- BUSY:
  - `cnt` != 0: assert all three holds and decrement `cnt`.
  - `cnt` == 0: deassert all holds, assert `mdu_done`, go to IDLE. `id_mdu_start` is not re-evaluated this cycle; the MDU instruction advances into ID/EXE.
- `lu` is never evaluated in BUSY. The EXE stage holds only bubbles there, so no load can be present.
- `mdu_busy` = (state == BUSY), including the release cycle.
- Outputs are a Moore/Mealy mix: holds and `mdu_done` are combinational from state, `cnt` and the hazard inputs. They are registered by their consumers.

## Timing
- Reset:
  - While `rst` = 1, `pc_hold`, `if_id_hold`, `pause`, `mdu_busy` and `mdu_done` are forced 0.
  - At the next edge: state = IDLE, `cnt` = 0, `stall_cycles` = 0.
- Reset mid-BUSY: the stall is abandoned immediately, with no `mdu_done` pulse. The next edge starts in IDLE.
- Load-use penalty is exactly 1 cycle. In the following cycle the load is in MEM, EXE holds a bubble, and `lu` = 0.
- MDU penalty is exactly N cycles (N = `MUL_CYCLES` or `DIV_CYCLES`): holds are asserted from T0 through T(N−1), and `mdu_done` is asserted at T(N).
  - N = 1: hold at T0 only, BUSY at T1 with `cnt` = 0, release at T1.
- Simultaneous `lu` and `id_mdu_start`: the load-use bubble comes first. The MDU sequence starts on the next cycle (T0 shifts by one), for a total penalty of 1 + N.
- Back-to-back MDU instructions: the second one's T0 is the cycle after the first one's release.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
- Defined: `stall_cycles` is a 32-bit register. It increments on every clock edge where `pause` = 1 and `rst` = 0, and wraps from 0xFFFFFFFF to 0.
- Undefined: no counter logic is compiled; `stall_cycles` is tied to 32'h0.

## Test plan
- Load-use: EXE holds load with `ex_reg_write_addr` = 8, `ex_RegWE` = 1, `ex_is_load` = 1; ID has `id_rs` = 8, `id_uses_rs` = 1 -> `pause`/`pc_hold`/`if_id_hold` = 1 for exactly 1 cycle, then 0.
- No false stall: same as above but `ex_reg_write_addr` = 0, or `id_uses_rs` = 0, or `ex_is_load` = 0 -> all holds stay 0.
- Divide with `DIV_CYCLES` = 32: `id_mdu_start` = 1, `id_mdu_div` = 1 -> holds high for 32 cycles, `mdu_done` pulses on cycle 32, `mdu_busy` high on cycles 1..32.
- Priority: `lu` and `id_mdu_start` (multiply, `MUL_CYCLES` = 4) in the same cycle -> 1 bubble, then 4 MDU stall cycles, `mdu_done` at cycle 5.
- Reset mid-operation: `rst` = 1 at BUSY with `cnt` = 10 -> all outputs 0 that cycle, IDLE next, no `mdu_done`; with `HAZARD_PERF_CNT_EN`, `stall_cycles` reads 0.
- Perf counter: with `HAZARD_PERF_CNT_EN`, preload so `stall_cycles` reaches 0xFFFFFFFF, then one stall cycle -> wraps to 0. Without the macro -> `stall_cycles` is always 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline stall controller beside the ID stage. Inserts one bubble on a
// load-use hazard and holds a multi-cycle multiply/divide in ID until the
// MDU result is ready.
//
// Optional feature macro: HAZARD_PERF_CNT_EN. When defined, stall_cycles
// counts the cycles in which pause was asserted. When undefined, stall_cycles
// is tied to zero.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   id_rs, id_rt        source register fields of the ID instruction
//   id_uses_rs/_rt      ID instruction reads rs / rt
//   id_mdu_start        ID instruction is a multi-cycle MDU op
//   id_mdu_div          1 = divide, 0 = multiply (qualified by id_mdu_start)
//   ex_reg_write_addr   destination register of the EXE instruction
//   ex_RegWE            EXE instruction writes the register file
//   ex_is_load          EXE instruction writes back memory data
//   pc_hold             freeze PC (combinational)
//   if_id_hold          freeze IF/ID register (combinational)
//   pause               load a bubble into ID/EXE (combinational)
//   mdu_busy            MDU stall state is active (combinational)
//   mdu_done            one-cycle pulse on the MDU release cycle (combinational)
//   stall_cycles        stall performance counter
module hazard_stall_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_mdu_start,
  input  logic        id_mdu_div,
  input  logic [4:0]  ex_reg_write_addr,
  input  logic        ex_RegWE,
  input  logic        ex_is_load,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        pause,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned PERF_W = 32;

  // The counter is loaded with N-1 so the release lands exactly N cycles after T0.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;
  logic               hold;
  logic               done;
  logic               busy;

  // Load-use hazard between the ID sources and a load in EXE.
  always_comb begin
    lu = ex_is_load & ex_RegWE & (ex_reg_write_addr != 5'd0) &
         ((id_uses_rs & (id_rs == ex_reg_write_addr)) |
          (id_uses_rt & (id_rt == ex_reg_write_addr)));
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        // The load-use bubble wins; an MDU start waits for the next cycle.
        if (lu) begin
          hold = 1'b1;
        end else if (id_mdu_start) begin
          hold    = 1'b1;
          cnt_d   = id_mdu_div ? DIV_LOAD : MUL_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // EXE holds only bubbles here, so no load-use check is needed.
        busy = 1'b1;
        if (cnt_q != '0) begin
          hold  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset suppresses all outputs in the cycle it is asserted.
    if (rst) begin
      hold = 1'b0;
      done = 1'b0;
      busy = 1'b0;
    end
  end

  assign pc_hold    = hold;
  assign if_id_hold = hold;
  assign pause      = hold;
  assign mdu_busy   = busy;
  assign mdu_done   = done;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  // Counts bubble cycles; wraps naturally at the top of the range.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (hold) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = PERF_W'(0);
`endif

endmodule
